// File: rtl/inst_fetch_buffer_pkg.sv
// Purpose : shared constants for the instruction fetch buffer (FSM encoding, widths, NOP).
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: fetch FSM state encoding, default data width, NOP used for decode bubbles.
package inst_fetch_buffer_pkg;

   localparam int XLEN = 32;

   // Fetch FSM encoding, kept as plain 2-bit constants for legacy tools.
   localparam logic [1:0] ST_IDLE = 2'd0;  // no read outstanding
   localparam logic [1:0] ST_WAIT = 2'd1;  // read outstanding, response kept
   localparam logic [1:0] ST_DROP = 2'd2;  // read outstanding, response discarded

   // addi x0, x0, 0 -- what decode inserts when it has no valid instruction.
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose : DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode.
// Latency : head visible combinationally the cycle after the push edge.
// Backpr. : caller must not push when full; pop is only legal when count != 0.
// Ports   : clk, rst (async active-low), flush (sync clear), push/push_data,
//           pop, head_data (entry at rd_ptr), count (occupancy, 0..DEPTH).
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage is left as-is; only the bookkeeping is squashed.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Purpose : issue one imem read at a time from current_pc and queue {pc, inst} for decode.
// Latency : request same cycle as IDLE; entry visible to decode the cycle after rvalid.
// Backpr. : stops issuing (pc_stall=1) while the FIFO is full or a read is outstanding.
// Ports   : clk, rst (async active-low); pc_in/pc_stall to the PC register; flush redirect;
//           imem_req/imem_addr/imem_rvalid/imem_rdata to instruction memory;
//           id_valid/id_pc/id_inst/id_ready toward decode.
module inst_fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_stall,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_inst,
   input  logic            id_ready
);

   import inst_fetch_buffer_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [XLEN-1:0]   req_pc;
   logic [CW-1:0]     count;
   logic              full;
   logic              issue;
   logic              push;
   logic              pop;
   logic [2*XLEN-1:0] head;

   assign full  = (count == CW'(DEPTH));
   assign issue = (state == ST_IDLE) & ~flush & ~full;

   assign imem_req  = issue;
   assign imem_addr = pc_in;

   // PC moves only when a fetch goes out, or on flush so the PC register takes the target.
   assign pc_stall = ~issue & ~flush;

   // Flush wins over everything: a response landing on the flush cycle is dropped.
   assign push     = (state == ST_WAIT) & imem_rvalid & ~flush;
   assign id_valid = (count != '0);
   assign pop      = id_valid & id_ready & ~flush;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data ({req_pc, imem_rdata}),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   assign id_pc   = head[2*XLEN-1:XLEN];
   assign id_inst = head[XLEN-1:0];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (issue) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // A flush without the response means the read is still in flight and stale.
            if (imem_rvalid)  state_nxt = ST_IDLE;
            else if (flush)   state_nxt = ST_DROP;
         end
         ST_DROP: begin
            if (imem_rvalid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            req_pc <= pc_in;
         end
      end
   end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Fetch-side companion to the PC register. Consumes current_pc, issues one instruction-memory read at a time, and buffers returned {pc, inst} pairs in a small FIFO toward decode.
- Drives the PC register's stall input so the PC only advances when a fetch is actually issued.
- Flushes on a resolved redirect and discards any in-flight stale response.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- XLEN, 32, address/instruction width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_in  in  XLEN  current_pc from PC register
- pc_stall  out  1  stall to PC register (1 = hold PC)
- flush  in  1  redirect this cycle (PC register loads target); squashes buffer
- imem_req  out  1  read request, single-cycle pulse
- imem_addr  out  XLEN  request address
- imem_rvalid  in  1  read data valid
- imem_rdata  in  XLEN  instruction word
- id_valid  out  1  head entry valid
- id_pc  out  XLEN  PC of head entry
- id_inst  out  XLEN  instruction of head entry
- id_ready  in  1  decode accepts head

Behaviour:
- FSM states:
  - IDLE: no read outstanding.
  - WAIT: read outstanding, response will be kept.
  - DROP: read outstanding, response will be discarded.
- issue = (state==IDLE) & !flush & (count < DEPTH).
- imem_req = issue; imem_addr = pc_in (both combinational). On issue, capture req_pc <= pc_in and go to WAIT.
- pc_stall = !issue & !flush.
  - PC advances exactly on issue cycles.
  - On flush, pc_stall=0 so the PC register loads the redirect target (stall has priority over branch in the PC register).
- WAIT:
  - On imem_rvalid, push {req_pc, imem_rdata} and go to IDLE.
  - Otherwise hold WAIT.
  - Memory latency ≥1 cycle, unbounded; rvalid in IDLE is ignored.
- Flush priority: flush overrides rvalid push, pop and issue in the same cycle. count, rd_ptr and wr_ptr are cleared.
  - IDLE+flush -> IDLE.
  - WAIT+flush with rvalid -> IDLE (response discarded).
  - WAIT+flush without rvalid -> DROP.
  - DROP+flush -> DROP unless rvalid, then IDLE.
- DROP: on rvalid discard and go to IDLE; pc_stall=1 meanwhile, holding the target PC.
- Pop when id_valid & id_ready. Push and pop in the same cycle leaves count unchanged. Push into full is impossible, since issue requires count<DEPTH and only one read is outstanding.
- id_valid = (count != 0). id_pc/id_inst come from the head entry, combinationally from storage.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency (IDLE→WAIT→IDLE); back-to-back issue is out of scope.
- Async reset (rst=0):
  - state=IDLE; count, rd_ptr, wr_ptr = 0; req_pc=0; all storage=0.
  - Outputs: id_valid=0, id_pc=0, id_inst=0. imem_req=1 and pc_stall=0 when count<DEPTH. This is harmless because the PC register is itself held in reset.
- Reset asserted mid-WAIT: returns to IDLE and a late rvalid is ignored. Memory must be reset together with this block.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2)
  - XLEN constant
  - NOP instruction constant 32'h00000013, for decode bubbles
- One natural sub-module: fetch_fifo (parameterised DEPTH×(2·XLEN) storage, rd/wr pointers, count, synchronous flush). The FSM and issue logic stay in the top.

Test Plan:
- Reset then release, pc_in=0, 1-cycle memory, id_ready=1:
  - imem_req pulses at addr 0x0, 0x4, 0x8 on alternate cycles.
  - id outputs {0x0, mem[0]}, {0x4, mem[1]} in order.
  - pc_stall high exactly in WAIT cycles.
- id_ready=0, DEPTH=4:
  - After 4 pushes (0x0..0xC), issue stops; pc_stall stays 1 and imem_req=0.
  - One pop re-enables issue at 0x10.
- Flush in WAIT without rvalid, redirect to 0x100, response arrives 3 cycles later:
  - Response discarded, id_valid=0.
  - Next req addr=0x100, pc_stall=0 on the flush cycle.
- Flush coincident with rvalid in WAIT: no push, state IDLE next cycle, FIFO empty.
- Simultaneous push and pop with count=2: count stays 2, head advances, order preserved.
- rst deasserted→asserted mid-WAIT with 2 entries buffered: id_valid=0 immediately (async), state IDLE; late rvalid produces no push.
